// File: rtl/clock_divider_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   MIN_DIV    : smallest divisor a channel will run at.
//   clamp_div(): raises any captured divisor below MIN_DIV up to MIN_DIV.
// Divisors are carried as 32-bit values here, so channel WIDTH must be <= 32.
package clock_divider_pkg;

  localparam int unsigned MIN_DIV = 2;

  // Clamp a divisor to the minimum usable ratio (0 and 1 become 2).
  function automatic logic [31:0] clamp_div(input logic [31:0] value);
    logic [31:0] result;
    if (value < 32'(MIN_DIV)) begin
      result = 32'(MIN_DIV);
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: phase counter, active/pending divisor and output regs.
// Ports:
//   clk     : clock, all state on posedge
//   rst     : synchronous active-high reset
//   en      : count enable; low freezes phase, divisor and square output
//   sync    : forces a period wrap in this cycle (when enabled)
//   load    : captures clamped div_in as the pending divisor
//   div_in  : divisor value for load
//   o       : registered square output, high for floor(D/2) cycles
//   stb     : registered one-cycle pulse in phase 0
//   pending : a loaded divisor is waiting for the next period boundary
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             o,
  output logic             stb,
  output logic             pending
);

  localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_LAST = WIDTH'(DEFAULT_DIV - 1);

  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] pend_div_r;
  logic             f_r;
  logic             o_r;
  logic             stb_r;

  logic [WIDTH-1:0] load_val_s;
  logic             wrap_s;
  logic [WIDTH-1:0] d_next_s;
  logic [WIDTH-1:0] p_next_s;
  logic [WIDTH-1:0] high_s;

  // Next phase and the divisor in force for it; a load coinciding with a
  // wrap takes priority over an older pending value.
  always_comb begin
    load_val_s = WIDTH'(clamp_div(32'(div_in)));
    wrap_s     = (p_r == (d_r - WIDTH'(1))) || sync;
    d_next_s   = d_r;
    if (wrap_s) begin
      if (load) begin
        d_next_s = load_val_s;
      end else if (f_r) begin
        d_next_s = pend_div_r;
      end else begin
        d_next_s = d_r;
      end
    end else begin
      d_next_s = d_r;
    end
    p_next_s = wrap_s ? '0 : (p_r + WIDTH'(1));
    high_s   = d_next_s >> 1;
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r        <= DEF_LAST;
      d_r        <= DEF_DIV;
      pend_div_r <= DEF_DIV;
      f_r        <= 1'b0;
      o_r        <= 1'b0;
      stb_r      <= 1'b0;
    end else if (en) begin
      p_r   <= p_next_s;
      d_r   <= d_next_s;
      o_r   <= (p_next_s < high_s);
      stb_r <= (p_next_s == '0);
      if (wrap_s) begin
        f_r <= 1'b0;
      end else if (load) begin
        pend_div_r <= load_val_s;
        f_r        <= 1'b1;
      end else begin
        f_r <= f_r;
      end
    end else begin
      // Frozen: phase, divisor and O hold, but loads are still captured.
      stb_r <= 1'b0;
      if (load) begin
        pend_div_r <= load_val_s;
        f_r        <= 1'b1;
      end else begin
        f_r <= f_r;
      end
    end
  end

  assign o       = o_r;
  assign stb     = stb_r;
  assign pending = f_r;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable clock divider.
// Ports:
//   I       : clock, all logic on posedge
//   R       : synchronous active-high reset
//   E       : global count enable
//   sync    : one-cycle pulse restarting every channel at phase 0
//   load    : per-channel load strobe for div_in
//   div_in  : divisors, channel k at [k*WIDTH +: WIDTH]
//   pending : per-channel loaded-but-not-applied flag
//   O       : per-channel divided square outputs
//   stb     : per-channel one-cycle pulse at phase 0
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic                      I,
  input  logic                      R,
  input  logic                      E,
  input  logic                      sync,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] div_in,
  output logic [CHANNELS-1:0]       pending,
  output logic [CHANNELS-1:0]       O,
  output logic [CHANNELS-1:0]       stb
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    clock_divider_channel #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk    (I),
      .rst    (R),
      .en     (E),
      .sync   (sync),
      .load   (load[k]),
      .div_in (div_in[k*WIDTH +: WIDTH]),
      .o      (O[k]),
      .stb    (stb[k]),
      .pending(pending[k])
    );
  end

endmodule
